wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_if.sv | 32 +++
 rtl/wb_stage.sv | 162 ++++++++++++++++
 tb/tb_wb_stage.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// MEM -> WB handshake bundle: result handoff plus data-memory read return.
// master drives the result and dmem strobe; slave (WB) returns in_ready.
interface wb_stage_if #(
   parameter int XLEN  = 32,
   parameter int RSLEN = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [RSLEN-1:0] in_rd;
   logic             in_wen;
   logic             in_is_load;
   logic [1:0]       in_ld_size;
   logic             in_ld_unsigned;
   logic [1:0]       in_addr_lo;
   logic [XLEN-1:0]  in_alu;
   logic             dmem_rvalid;
   logic [XLEN-1:0]  dmem_rdata;

   modport master (
      output in_valid, in_rd, in_wen, in_is_load,
      output in_ld_size, in_ld_unsigned, in_addr_lo,
      output in_alu, dmem_rvalid, dmem_rdata,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_rd, in_wen, in_is_load,
      input  in_ld_size, in_ld_unsigned, in_addr_lo,
      input  in_alu, dmem_rvalid, dmem_rdata,
      output in_ready
   );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: registers ALU results, waits for load data, drives the RF.
// Ports: clk, rst (async low), mem (wb_stage_if.slave), wb_e/w_baddr/wb_data
// RF write, ld_pending/ld_rd hazard info, retire_cnt completions.
// Sub-word load extraction is built only with WB_SUBWORD_EN defined.
module wb_stage #(
   parameter  int XLEN     = 32,
   parameter  int NUM_REGS = 32,
   localparam int RSLEN    = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             rst,
   wb_stage_if.slave        mem,
   output logic             wb_e,
   output logic [RSLEN-1:0] w_baddr,
   output logic [XLEN-1:0]  wb_data,
   output logic             ld_pending,
   output logic [RSLEN-1:0] ld_rd,
   output logic [31:0]      retire_cnt
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t           state_q, state_d;
   logic [RSLEN-1:0] ldrd_q, ldrd_d;
   logic             ldwen_q, ldwen_d;
   logic             wbe_q, wbe_d;
   logic [RSLEN-1:0] waddr_q, waddr_d;
   logic [XLEN-1:0]  wdata_q, wdata_d;
   logic [31:0]      cnt_q, cnt_d;
   logic [XLEN-1:0]  ld_data;

   logic             done;
   logic             wr_en;
   logic [RSLEN-1:0] wr_rd;
   logic [XLEN-1:0]  wr_data;

`ifdef WB_SUBWORD_EN
   logic [1:0] size_q, size_d;
   logic       uns_q, uns_d;
   logic [1:0] lo_q, lo_d;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;

   // Half select uses only lo[1]; lo[0] of a half load is ignored.
   always_comb begin
      ld_b = mem.dmem_rdata[{lo_q, 3'b000} +: 8];
      ld_h = mem.dmem_rdata[{lo_q[1], 4'b0000} +: 16];
      unique case (1'b1)
         (size_q == 2'b00):
            ld_data = {{(XLEN-8){~uns_q & ld_b[7]}}, ld_b};
         (size_q == 2'b01):
            ld_data = {{(XLEN-16){~uns_q & ld_h[15]}}, ld_h};
         default:
            ld_data = mem.dmem_rdata;
      endcase
   end
`else
   logic unused_sub;

   assign unused_sub = ^{mem.in_ld_size, mem.in_ld_unsigned,
                         mem.in_addr_lo};
   assign ld_data    = mem.dmem_rdata;
`endif

   always_comb begin
      state_d = state_q;
      ldrd_d  = ldrd_q;
      ldwen_d = ldwen_q;
      wbe_d   = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      done    = 1'b0;
      wr_en   = 1'b0;
      wr_rd   = '0;
      wr_data = '0;
`ifdef WB_SUBWORD_EN
      size_d  = size_q;
      uns_d   = uns_q;
      lo_d    = lo_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (mem.in_valid) begin
               if (mem.in_is_load) begin
                  ldrd_d  = mem.in_rd;
                  ldwen_d = mem.in_wen;
`ifdef WB_SUBWORD_EN
                  size_d  = mem.in_ld_size;
                  uns_d   = mem.in_ld_unsigned;
                  lo_d    = mem.in_addr_lo;
`endif
                  state_d = WAIT;
               end else begin
                  done    = 1'b1;
                  wr_en   = mem.in_wen;
                  wr_rd   = mem.in_rd;
                  wr_data = mem.in_alu;
               end
            end
         end
         WAIT: begin
            if (mem.dmem_rvalid) begin
               done    = 1'b1;
               wr_en   = ldwen_q;
               wr_rd   = ldrd_q;
               wr_data = ld_data;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (done) begin
         cnt_d = cnt_q + 32'd1;
      end
      // x0 is hardwired; address/data keep their last write otherwise.
      if (done && wr_en && (wr_rd != '0)) begin
         wbe_d   = 1'b1;
         waddr_d = wr_rd;
         wdata_d = wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ldrd_q  <= '0;
         ldwen_q <= 1'b0;
         wbe_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
`ifdef WB_SUBWORD_EN
         size_q  <= '0;
         uns_q   <= 1'b0;
         lo_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         ldrd_q  <= ldrd_d;
         ldwen_q <= ldwen_d;
         wbe_q   <= wbe_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
`ifdef WB_SUBWORD_EN
         size_q  <= size_d;
         uns_q   <= uns_d;
         lo_q    <= lo_d;
`endif
      end
   end

   assign mem.in_ready = (state_q == IDLE);
   assign ld_pending   = (state_q == WAIT);
   assign ld_rd        = ld_pending ? ldrd_q : '0;
   assign wb_e         = wbe_q;
   assign w_baddr      = waddr_q;
   assign wb_data      = wdata_q;
   assign retire_cnt   = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus random traffic
// against a transaction-level reference of register writes and retires.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wb_e;
   logic [4:0]  w_baddr;
   logic [31:0] wb_data;
   logic        ld_pending;
   logic [4:0]  ld_rd;
   logic [31:0] retire_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_cnt  = '0;
   logic [4:0]  exp_addr = '0;
   logic [31:0] exp_data = '0;

   wb_stage_if #(.XLEN(32), .RSLEN(5)) bus ();

   wb_stage #(.XLEN(32), .NUM_REGS(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem        (bus),
      .wb_e       (wb_e),
      .w_baddr    (w_baddr),
      .wb_data    (wb_data),
      .ld_pending (ld_pending),
      .ld_rd      (ld_rd),
      .retire_cnt (retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference load result computed arithmetically from the load rules.
   function automatic logic [31:0] ref_ext(input logic [31:0] d,
                                           input logic [1:0] sz,
                                           input logic uns,
                                           input logic [1:0] lo);
      longint unsigned v;
      v = longint'(d);
`ifdef WB_SUBWORD_EN
      if (sz == 2'd0) begin
         v = (longint'(d) >> (8 * int'(lo))) % 256;
         if (!uns && v >= 128) v = v + 64'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (longint'(d) >> (16 * (int'(lo) / 2))) % 65536;
         if (!uns && v >= 32768) v = v + 64'hFFFF_0000;
      end
`else
      if (sz == 2'd3 && uns && lo == 2'd3) v = longint'(d);
`endif
      return v[31:0];
   endfunction

   task automatic complete(input logic [4:0] rd, input logic wen,
                           input logic [31:0] val, output logic we);
      exp_cnt = exp_cnt + 32'd1;
      we = wen && (rd != 5'd0);
      if (we) begin
         exp_addr = rd;
         exp_data = val;
      end
   endtask

   task automatic check_wb(input string tag, input logic we);
      chk({tag, ".wb_e"}, wb_e, we);
      chk({tag, ".addr"}, w_baddr, exp_addr);
      chk({tag, ".data"}, wb_data, exp_data);
      chk({tag, ".cnt"}, retire_cnt, exp_cnt);
   endtask

   task automatic drive(input logic [4:0] rd, input logic wen,
                        input logic ld, input logic [1:0] sz,
                        input logic uns, input logic [1:0] lo,
                        input logic [31:0] alu);
      bus.in_valid       = 1'b1;
      bus.in_rd          = rd;
      bus.in_wen         = wen;
      bus.in_is_load     = ld;
      bus.in_ld_size     = sz;
      bus.in_ld_unsigned = uns;
      bus.in_addr_lo     = lo;
      bus.in_alu         = alu;
   endtask

   // Entered and left at a negedge with the stage idle.
   task automatic nonload(input string tag, input logic [4:0] rd,
                          input logic wen, input logic [31:0] alu);
      logic we;
      chk({tag, ".rdy"}, bus.in_ready, 1'b1);
      drive(rd, wen, 1'b0, 2'd2, 1'b0, 2'd0, alu);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      bus.in_alu = $urandom;
      complete(rd, wen, alu, we);
      @(negedge clk);
      check_wb(tag, we);
      @(negedge clk);
      chk({tag, ".pulse"}, wb_e, 1'b0);
   endtask

   task automatic load(input string tag, input logic [4:0] rd,
                       input logic wen, input logic [1:0] sz,
                       input logic uns, input logic [1:0] lo,
                       input logic [31:0] rdata, input int dly);
      logic we;
      chk({tag, ".rdy"}, bus.in_ready, 1'b1);
      drive(rd, wen, 1'b1, sz, uns, lo, $urandom);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      for (int i = 0; i <= dly; i++) begin
         @(negedge clk);
         chk({tag, ".busy"}, bus.in_ready, 1'b0);
         chk({tag, ".pend"}, ld_pending, 1'b1);
         chk({tag, ".ldrd"}, ld_rd, rd);
         chk({tag, ".nowr"}, wb_e, 1'b0);
      end
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = rdata;
      @(posedge clk);
      #1 bus.dmem_rvalid = 1'b0;
      bus.dmem_rdata = $urandom;
      complete(rd, wen, ref_ext(rdata, sz, uns, lo), we);
      @(negedge clk);
      check_wb(tag, we);
      chk({tag, ".done"}, ld_pending, 1'b0);
      @(negedge clk);
      chk({tag, ".pulse"}, wb_e, 1'b0);
   endtask

   initial begin
      logic we;
      bus.in_valid       = 1'b0;
      bus.in_rd          = '0;
      bus.in_wen         = 1'b0;
      bus.in_is_load     = 1'b0;
      bus.in_ld_size     = '0;
      bus.in_ld_unsigned = 1'b0;
      bus.in_addr_lo     = '0;
      bus.in_alu         = '0;
      bus.dmem_rvalid    = 1'b0;
      bus.dmem_rdata     = '0;

      repeat (2) @(negedge clk);
      chk("rst.wb_e", wb_e, 1'b0);
      chk("rst.addr", w_baddr, 5'd0);
      chk("rst.data", wb_data, 32'd0);
      chk("rst.pend", ld_pending, 1'b0);
      chk("rst.ldrd", ld_rd, 5'd0);
      chk("rst.cnt", retire_cnt, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("rel.rdy", bus.in_ready, 1'b1);

      // Stray read strobe while idle
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = 32'hDEAD_BEEF;
      @(posedge clk);
      #1 bus.dmem_rvalid = 1'b0;
      @(negedge clk);
      check_wb("idle_rv", 1'b0);
      chk("idle_rv.pend", ld_pending, 1'b0);

      nonload("alu5", 5'd5, 1'b1, 32'h1234_5678);
      load("lb3", 5'd7, 1'b1, 2'd0, 1'b0, 2'd3, 32'h80FF_0011, 3);
      load("lhu2", 5'd8, 1'b1, 2'd1, 1'b1, 2'd2, 32'hBEEF_1234, 0);
      load("lh2", 5'd9, 1'b1, 2'd1, 1'b0, 2'd2, 32'hBEEF_1234, 1);
      load("lh3", 5'd10, 1'b1, 2'd1, 1'b0, 2'd3, 32'h7FFF_8001, 0);
      load("lw", 5'd11, 1'b1, 2'd2, 1'b0, 2'd1, 32'hCAFE_F00D, 2);
      load("l11", 5'd12, 1'b1, 2'd3, 1'b1, 2'd2, 32'h0123_4567, 0);
      nonload("x0", 5'd0, 1'b1, 32'hFFFF_FFFF);
      nonload("nowen", 5'd9, 1'b0, 32'h5555_AAAA);
      load("ldx0", 5'd0, 1'b1, 2'd2, 1'b0, 2'd0, 32'h1111_2222, 1);

      // Next instruction held valid across a WAIT
      drive(5'd14, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 32'd0);
      @(posedge clk);
      #1 drive(5'd15, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 32'hA5A5_0F0F);
      repeat (2) begin
         @(negedge clk);
         chk("hold.busy", bus.in_ready, 1'b0);
         chk("hold.nowr", wb_e, 1'b0);
         chk("hold.cnt", retire_cnt, exp_cnt);
      end
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = 32'h0BAD_CAFE;
      @(posedge clk);
      #1 bus.dmem_rvalid = 1'b0;
      complete(5'd14, 1'b1, 32'h0BAD_CAFE, we);
      @(negedge clk);
      check_wb("hold.ld", we);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      complete(5'd15, 1'b1, 32'hA5A5_0F0F, we);
      @(negedge clk);
      check_wb("hold.alu", we);
      @(negedge clk);

      for (int t = 0; t < 40; t++) begin
         logic [4:0] rd;
         logic wen;
         rd  = 5'($urandom_range(0, 31));
         wen = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1)
            load("rnd.ld", rd, wen, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 $urandom, $urandom_range(0, 3));
         else
            nonload("rnd.alu", rd, wen, $urandom);
      end

      // Counter wrap via preload
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1 release dut.cnt_q;
      exp_cnt = 32'hFFFF_FFFF;
      chk("wrap.pre", retire_cnt, exp_cnt);
      nonload("wrap", 5'd3, 1'b1, 32'h0000_0042);
      chk("wrap.zero", retire_cnt, 32'd0);

      // Reset while a load is outstanding
      drive(5'd4, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 32'd0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk("rw.pend", ld_pending, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("rw.pend0", ld_pending, 1'b0);
      chk("rw.ldrd0", ld_rd, 5'd0);
      chk("rw.cnt0", retire_cnt, 32'd0);
      chk("rw.addr0", w_baddr, 5'd0);
      chk("rw.data0", wb_data, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = 32'h7777_7777;
      @(posedge clk);
      #1 bus.dmem_rvalid = 1'b0;
      @(negedge clk);
      chk("rw.nowr", wb_e, 1'b0);
      chk("rw.pend", ld_pending, 1'b0);
      chk("rw.cnt", retire_cnt, 32'd0);
      chk("rw.rdy", bus.in_ready, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
